// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared constants for the LED sequencer: pattern mode codes,
//                bounce direction codes and the prescaler width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    // Pattern mode select codes
    localparam logic [1:0] MODE_ROT_L  = 2'd0;
    localparam logic [1:0] MODE_ROT_R  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BAR    = 2'd3;

    // Bounce direction codes
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Counter width able to hold 0..ticks-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned ticks);
        return (ticks <= 1) ? 1 : $clog2(ticks);
    endfunction

endpackage : led_pkg
`default_nettype wire

// File: rtl/tick_div.sv
`default_nettype none
// ============================================================================
//  Module      : tick_div
//  Description : Prescaler. Counts enabled cycles 0..TICKS-1 and raises tick
//                combinationally in the enabled cycle where the count is at
//                its last value; the count then returns to zero.
//  Ports       : clk100m - clock
//                rst     - synchronous active-high reset (count -> 0)
//                en      - count enable; when low the count holds
//                clr     - synchronous clear, overrides en
//                tick    - terminal-count strobe (en && count == TICKS-1)
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_div
    import led_pkg::*;
#(
    parameter int unsigned TICKS = 50000000
) (
    input  logic clk100m,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   CW   = cnt_width(TICKS);
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk100m) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : tick_div
`default_nettype wire

// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_gen
//  Description : LED bank sequencer. A prescaler divides the clock to a step
//                rate; each step advances the LED vector by the selected
//                pattern (rotate left, rotate right, bounce, bar fill).
//  Ports       : clk100m - 100 MHz system clock
//                rst     - synchronous active-high reset
//                mode    - pattern select (0 rotl, 1 rotr, 2 bounce, 3 bar)
//                run     - 1 advances, 0 freezes prescaler and pattern
//                leds    - registered LED drive
//                step    - one-cycle pulse in the cycle the pattern advances
//                wrap    - pulse with step when the pattern hits its start
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int          WIDTH = 16,
    parameter int unsigned TICKS = 50000000
) (
    input  logic             clk100m,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             run,
    output logic [WIDTH-1:0] leds,
    output logic             step,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Bar fill starts empty; every other mode starts with bit0 lit
    function automatic logic [WIDTH-1:0] start_val(input logic [1:0] m);
        return (m == MODE_BAR) ? '0 : ONE;
    endfunction

    logic [1:0]       mode_q;
    logic [WIDTH-1:0] leds_q, leds_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] pat_next;
    logic             dir_next;
    logic             pat_wrap;
    logic             mode_chg;
    logic             tick;

    assign mode_chg = (mode != mode_q);

    tick_div #(
        .TICKS   (TICKS)
    ) u_tick_div (
        .clk100m (clk100m),
        .rst     (rst),
        .en      (run),
        .clr     (mode_chg),
        .tick    (tick)
    );

    // Pattern advance for the mode currently in effect. On a tick mode_q
    // equals mode, since any difference takes the mode-change path instead.
    always_comb begin
        pat_next = leds_q;
        dir_next = dir_q;
        pat_wrap = 1'b0;
        case (mode_q)
            MODE_ROT_L: begin
                // Shift form stays correct for WIDTH=1 (result equals input)
                pat_next = (leds_q << 1) | (leds_q >> (WIDTH - 1));
                pat_wrap = (pat_next == ONE);
            end
            MODE_ROT_R: begin
                pat_next = (leds_q >> 1) | (leds_q << (WIDTH - 1));
                pat_wrap = (pat_next == ONE);
            end
            MODE_BOUNCE: begin
                if (WIDTH == 1) begin
                    pat_next = ONE;
                    dir_next = DIR_LEFT;
                end else if (dir_q == DIR_LEFT) begin
                    // Reversal and first move back happen in the same step
                    if (leds_q[WIDTH-1]) begin
                        dir_next = DIR_RIGHT;
                        pat_next = leds_q >> 1;
                    end else begin
                        pat_next = leds_q << 1;
                    end
                end else begin
                    if (leds_q[0]) begin
                        dir_next = DIR_LEFT;
                        pat_next = leds_q << 1;
                    end else begin
                        pat_next = leds_q >> 1;
                    end
                end
                pat_wrap = (pat_next == ONE);
            end
            default: begin
                // Thermometer fill, then clear once full
                pat_next = (&leds_q) ? '0 : ((leds_q << 1) | ONE);
                pat_wrap = (pat_next == '0);
            end
        endcase
    end

    // Mode change restarts the pattern and beats a coincident tick
    always_comb begin
        leds_d = leds_q;
        dir_d  = dir_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        if (mode_chg) begin
            leds_d = start_val(mode);
            dir_d  = DIR_LEFT;
        end else if (tick) begin
            leds_d = pat_next;
            dir_d  = dir_next;
            step_d = 1'b1;
            wrap_d = pat_wrap;
        end
    end

    always_ff @(posedge clk100m) begin
        if (rst) begin
            mode_q <= mode;
            leds_q <= start_val(mode);
            dir_q  <= DIR_LEFT;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            mode_q <= mode;
            leds_q <= leds_d;
            dir_q  <= dir_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    assign leds = leds_q;
    assign step = step_q;
    assign wrap = wrap_q;

endmodule : led_pattern_gen
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pattern_gen
//  Description : Self-checking bench for led_pattern_gen (WIDTH=4, TICKS=3
//                plus a WIDTH=1, TICKS=1 instance). Vector table, directed
//                corner sequences and a random run against a step-count model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

    localparam int W = 4;
    localparam int T = 3;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, run;
    logic [1:0]   mode;
    logic [W-1:0] leds;
    logic         step, wrap;

    logic         rst1, run1;
    logic [1:0]   mode1;
    logic [0:0]   leds1;
    logic         step1, wrap1;

    led_pattern_gen #(.WIDTH(W), .TICKS(T)) dut (
        .clk100m (clk),
        .rst     (rst),
        .mode    (mode),
        .run     (run),
        .leds    (leds),
        .step    (step),
        .wrap    (wrap)
    );

    led_pattern_gen #(.WIDTH(1), .TICKS(1)) dut1 (
        .clk100m (clk),
        .rst     (rst1),
        .mode    (mode1),
        .run     (run1),
        .leds    (leds1),
        .step    (step1),
        .wrap    (wrap1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: number of steps taken since the last restart plus
    // run cycles elapsed toward the next step.
    int         m_phase;
    int         m_cnt;
    logic [1:0] m_mode;
    logic       m_step, m_wrap;

    function automatic int period(input logic [1:0] m);
        case (m)
            2'd0, 2'd1: return W;
            2'd2:       return (W > 1) ? 2 * W - 2 : 1;
            default:    return W + 1;
        endcase
    endfunction

    function automatic logic [W-1:0] pat(input logic [1:0] m, input int ph);
        int p;
        int pos;
        logic [W-1:0] v;
        p = ph % period(m);
        v = '0;
        case (m)
            2'd0:    pos = p;
            2'd1:    pos = (W - p) % W;
            2'd2:    pos = (p < W) ? p : 2 * W - 2 - p;
            default: pos = -1;
        endcase
        if (pos >= 0) v[pos] = 1'b1;
        else for (int i = 0; i < p; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_step();
        if (rst || mode != m_mode) begin
            m_phase = 0;
            m_cnt   = 0;
            m_mode  = mode;
            m_step  = 1'b0;
            m_wrap  = 1'b0;
        end else if (run) begin
            if (m_cnt + 1 == T) begin
                m_cnt   = 0;
                m_phase = m_phase + 1;
                m_step  = 1'b1;
                m_wrap  = (m_phase % period(m_mode)) == 0;
            end else begin
                m_cnt  = m_cnt + 1;
                m_step = 1'b0;
                m_wrap = 1'b0;
            end
        end else begin
            m_step = 1'b0;
            m_wrap = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset(input logic [1:0] m);
        rst  = 1'b1;
        mode = m;
        run  = 1'b1;
        cyc();
        cyc();
        rst  = 1'b0;
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] mode;
        logic       run;
        int         n;
        logic [3:0] leds;
        logic       step;
        logic       wrap;
    } vec_t;

    vec_t tbl[21];

    initial begin
        logic ok;
        logic early;

        rst = 1'b1; run = 1'b0; mode = 2'd0;
        rst1 = 1'b1; run1 = 1'b0; mode1 = 2'd2;

        // inputs held for n cycles, outputs checked after the last edge
        tbl[0]  = '{1'b1, 2'd0, 1'b1, 2, 4'b0001, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 2'd0, 1'b1, 2, 4'b0001, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 2'd0, 1'b1, 1, 4'b0010, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 2'd0, 1'b1, 3, 4'b0100, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 3, 4'b1000, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 3, 4'b0001, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 2'd2, 1'b1, 1, 4'b0001, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 2'd2, 1'b1, 3, 4'b0010, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 2'd2, 1'b1, 3, 4'b0100, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 2'd2, 1'b1, 3, 4'b1000, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 2'd2, 1'b1, 3, 4'b0100, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 2'd2, 1'b1, 3, 4'b0010, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 2'd2, 1'b1, 3, 4'b0001, 1'b1, 1'b1};
        tbl[13] = '{1'b0, 2'd2, 1'b1, 3, 4'b0010, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 2'd3, 1'b1, 1, 4'b0000, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 2'd3, 1'b1, 3, 4'b0001, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 2'd3, 1'b1, 3, 4'b0011, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 2'd3, 1'b1, 3, 4'b0111, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 2'd3, 1'b1, 3, 4'b1111, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 2'd3, 1'b1, 3, 4'b0000, 1'b1, 1'b1};
        tbl[20] = '{1'b0, 2'd3, 1'b1, 3, 4'b0001, 1'b1, 1'b0};

        for (int i = 0; i < 21; i++) begin
            rst  = tbl[i].rst;
            mode = tbl[i].mode;
            run  = tbl[i].run;
            early = 1'b0;
            for (int k = 0; k < tbl[i].n; k++) begin
                cyc();
                if (k < tbl[i].n - 1 && step !== 1'b0) early = 1'b1;
            end
            check($sformatf("vec%0d", i), {early, leds, step, wrap},
                  {1'b0, tbl[i].leds, tbl[i].step, tbl[i].wrap});
        end

        // Pause and resume mid-count
        do_reset(2'd0);
        repeat (7) cyc();
        check("pause_pre", {leds, step}, {4'b0100, 1'b0});
        run = 1'b0;
        ok = 1'b1;
        repeat (10) begin
            cyc();
            if (leds !== 4'b0100 || step !== 1'b0 || wrap !== 1'b0) ok = 1'b0;
        end
        check("pause_hold", ok, 1'b1);
        run = 1'b1;
        cyc();
        check("resume_1", {leds, step}, {4'b0100, 1'b0});
        cyc();
        check("resume_2", {leds, step, wrap}, {4'b1000, 1'b1, 1'b0});

        // Mode change in the tick cycle
        do_reset(2'd0);
        cyc();
        cyc();
        mode = 2'd1;
        cyc();
        check("chg_at_tick", {leds, step, wrap}, {4'b0001, 1'b0, 1'b0});
        ok = 1'b1;
        repeat (2) begin
            cyc();
            if (step !== 1'b0 || leds !== 4'b0001) ok = 1'b0;
        end
        check("chg_quiet", ok, 1'b1);
        cyc();
        check("chg_first_step", {leds, step, wrap}, {4'b1000, 1'b1, 1'b0});

        // Reset while bouncing rightward
        do_reset(2'd2);
        repeat (12) cyc();
        check("bounce_right", {leds, step}, {4'b0100, 1'b1});
        rst = 1'b1;
        cyc();
        check("rst_mid_bounce", {leds, step, wrap}, {4'b0001, 1'b0, 1'b0});
        rst = 1'b0;
        repeat (3) cyc();
        check("after_rst_left", {leds, step, wrap}, {4'b0010, 1'b1, 1'b0});

        // Reset with simultaneous mode change, then a change while paused
        rst = 1'b1;
        mode = 2'd3;
        cyc();
        check("rst_with_chg", {leds, step, wrap}, {4'b0000, 1'b0, 1'b0});
        rst = 1'b0;
        run = 1'b0;
        mode = 2'd1;
        cyc();
        check("chg_paused", {leds, step, wrap}, {4'b0001, 1'b0, 1'b0});
        run = 1'b1;
        repeat (3) cyc();
        check("paused_chg_step", {leds, step, wrap}, {4'b1000, 1'b1, 1'b0});

        // Randomized run against the step-count model
        do_reset(2'd0);
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 79) == 0) mode = 2'($urandom_range(0, 3));
            run = ($urandom_range(0, 3) != 0);
            cyc();
            check("rand", {leds, step, wrap}, {pat(m_mode, m_phase), m_step, m_wrap});
        end
        rst = 1'b0;

        // Single-LED, every-cycle-step instance
        rst1 = 1'b1;
        run1 = 1'b1;
        cyc();
        cyc();
        check("w1_reset", {leds1, step1, wrap1}, 3'b100);
        rst1 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cyc();
            check($sformatf("w1_step%0d", c), {leds1, step1, wrap1}, 3'b111);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_led_pattern_gen
`default_nettype wire

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED sequencer driving the board LED bank from the 100 MHz system clock. A prescaler divides the clock to a step rate, and on each step the LED vector advances according to a selectable pattern mode: rotate left, rotate right, bounce, or bar fill. It also provides run/pause control and step/wrap strobes for other logic. It sits directly under the board top level and replaces the fixed single-pattern blinker.

Parameters:
WIDTH, 16, number of LEDs (legal range 1..32).
TICKS, 50000000, clock cycles per pattern step (legal range 1..2^32-1).

Ports:
clk100m  input  1  system clock, 100 MHz; the only clock.
rst  input  1  reset; synchronous, active-high.
mode  input  2  pattern select: 0 rotate-left, 1 rotate-right, 2 bounce, 3 bar fill.
run  input  1  1 = advance; 0 = freeze prescaler and pattern.
leds  output  WIDTH  LED drive, registered.
step  output  1  one-cycle pulse in the cycle the pattern advances.
wrap  output  1  one-cycle pulse coincident with step when the pattern returns to its start value.

Behaviour:
- Interface: one clock (clk100m); reset (rst) is synchronous and active-high. All state updates only on posedge clk100m.
- Reset: leds = start value of the current mode, prescaler = 0, dir = left, mode_q = mode, step = 0, wrap = 0.
- Start values: modes 0, 1 and 2 start at bit0 set (1 followed by zeros). Mode 3 starts at all zeros.
- Prescaler: counts 0..TICKS-1 while run=1. A tick occurs in the cycle where count == TICKS-1; count then returns to 0. A step therefore happens exactly every TICKS run-cycles. With TICKS=1, every run cycle is a tick. Width is clog2(TICKS), minimum 1.
- run=0: prescaler and pattern hold, step=wrap=0. Resuming continues from the held count, with no lost or extra cycles.
- On tick, leds register update and step=1 take effect in the following cycle. leds changes in the same cycle that step is high.
- Mode 0: rotate left, MSB wraps to bit0. wrap when the result equals the start value.
- Mode 1: rotate right, bit0 wraps to MSB. wrap when the result equals the start value.
- Mode 2 bounce: a single lit bit moves by one position per step in direction dir.
  - At bit WIDTH-1 with dir=left, dir flips and the bit moves to WIDTH-2 in the same step. There is no dwell at the end.
  - The mirror behaviour applies at bit0 with dir=right.
  - wrap when the bit arrives at bit0.
  - WIDTH=1: the bit stays at bit0 and wrap pulses every step.
- Mode 3 bar: a thermometer bar grows from bit0 (0, 1, 3, 7, … all-ones), then clears to 0. This is a WIDTH+1 state cycle. wrap on the transition to 0.
- Mode change: mode is sampled every cycle and mode_q holds the previous sample. When mode != mode_q, the next cycle has:
  - leds = start value of the new mode;
  - prescaler = 0;
  - dir = left;
  - step = wrap = 0.
  The mode change overrides a coincident tick. Mode change is applied even when run=0.
- rst asserted mid-step, mid-bounce or mid-change: the reset values win unconditionally in the next cycle.
- Arithmetic: all pattern updates stay within WIDTH bits, with no overflow into unused bits. The prescaler compare is an unsigned equality check.

Decomposition:
- Shared package led_pkg:
  - mode encoding constants MODE_ROT_L=0, MODE_ROT_R=1, MODE_BOUNCE=2, MODE_BAR=3;
  - direction constants DIR_LEFT=0, DIR_RIGHT=1.
- Sub-module tick_div (parameter TICKS; ports clk100m, rst, en, clr, tick). It contains the prescaler only. It will be reused by other timed blocks.
- Pattern next-state logic stays in led_pattern_gen.

Test Plan:
All scenarios use WIDTH=4 and TICKS=3 unless stated otherwise.
1. rst high 2 cycles, mode=0, run=1 -> leds=0001 after reset. Step pulses every 3 cycles. leds goes 0010, 0100, 1000, 0001, with wrap on the 4th step only.
2. mode=2, run=1 -> leds sequence 0010, 0100, 1000, 0100, 0010, 0001. wrap on the 0001 step. No repeated 1000 and no repeated 0001.
3. mode=3 -> leds sequence 0001, 0011, 0111, 1111, 0000. wrap on 0000. The cycle period is 5 steps (15 cycles).
4. mode=0 with leds=0100 and prescaler at 1; drop run for 10 cycles, then raise it -> leds stays 0100 with no step during the pause. The next step comes 2 cycles after run returns high.
5. Switch mode 0->1 in the exact cycle the tick fires -> next cycle leds=0001, step=0, prescaler=0. The first step after that comes 3 cycles later, with leds=1000.
6. Assert rst during bounce while dir=right -> leds=0001 and dir=left. Then check edge cases: WIDTH=1, TICKS=1, mode=2 -> leds constant 1, step and wrap high every cycle.
